vector_memory_arbiter: RTL and testbench

- Shares the single-port data memory (one write port, one read port, 64-bit words) between NUM_REQ vector load/store requesters.
- Each requester issues one burst of 1..2^LEN_WIDTH consecutive-word reads or writes.
- The arbiter grants requesters round-robin, sequences one memory access per cycle, and routes read data back tagged by requester.
- Sits between the vector LSU/scalar LSU and the memory module.

---
 rtl/vector_memory_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_vector_memory_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_memory_arbiter.sv
// vector_memory_arbiter
//   Shares one single-port data memory (separate read/write address ports,
//   DATA_WIDTH-bit words) between NUM_REQ vector/scalar load-store
//   requesters. Each requester issues one burst of reqLength+1 consecutive
//   word reads or writes. Grants are round-robin, one memory access is
//   sequenced per cycle, and read data is returned tagged by requester.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   reqValid/reqWrite     per-requester burst request and direction
//   reqAddress/reqLength  packed per-requester base word address / beats-1
//   reqWriteData          packed per-requester current write beat data
//   reqReady              one-cycle grant pulse
//   wdataTake             write beat consumed this cycle
//   rdataValid/rdataLast  read beat valid (per requester) / final beat
//   rdata                 read data, holds when no beat is valid
//   busy                  burst in progress (grant cycle through last cycle)
//   writeEnable, writeAddress, inputData, readAddress, outputData
//                         memory interface; outputData arrives one cycle
//                         after readAddress
//   accessError           only with ARB_BOUNDS_CHECK_EN: pulses the cycle
//                         after a grant whose burst falls outside MEM_SIZE
//
// Optional feature macro: ARB_BOUNDS_CHECK_EN (bounds-checked bursts).
//
// State | meaning
// IDLE  | waiting for a request; grant issued combinationally here
// WRITE | one memory write per cycle, beat 0..length
// READ  | one memory read address per cycle, beat 0..length
// DRAIN | last read beat returning (or rejected burst being retired)
module vector_memory_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 19,
  parameter int LEN_WIDTH     = 4,
  parameter int MEM_SIZE      = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              reqValid,
  input  logic [NUM_REQ-1:0]              reqWrite,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    reqLength,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqWriteData,
  output logic [NUM_REQ-1:0]              reqReady,
  output logic [NUM_REQ-1:0]              wdataTake,
  output logic [NUM_REQ-1:0]              rdataValid,
  output logic                            rdataLast,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            busy,
`ifdef ARB_BOUNDS_CHECK_EN
  output logic                            accessError,
`endif
  output logic                            writeEnable,
  output logic [ADDRESS_WIDTH-1:0]        readAddress,
  output logic [ADDRESS_WIDTH-1:0]        writeAddress,
  output logic [DATA_WIDTH-1:0]           inputData,
  input  logic [DATA_WIDTH-1:0]           outputData
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [PW-1:0]            ptr;
  logic [PW-1:0]            gnt;
  logic [PW-1:0]            gnt_sel;
  logic                     gnt_found;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]     len;
  logic [LEN_WIDTH-1:0]     beat;
  logic                     last_beat;
  logic [ADDRESS_WIDTH-1:0] beat_addr;
  logic [ADDRESS_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]     sel_len;
  logic                     bad;
  logic [NUM_REQ-1:0]       rvalid_q;
  logic                     rlast_q;
  logic [DATA_WIDTH-1:0]    rdata_hold;

  // Round-robin pick: first requesting index at or above ptr, wrapping.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_sel   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_found && reqValid[idx]) begin
        gnt_found = 1'b1;
        gnt_sel   = PW'(idx);
      end
    end
  end

  assign sel_base = reqAddress[int'(gnt_sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_len  = reqLength[int'(gnt_sel)*LEN_WIDTH +: LEN_WIDTH];

`ifdef ARB_BOUNDS_CHECK_EN
  // Extra carry bit catches bursts that wrap past the top of the address space.
  logic [ADDRESS_WIDTH:0] span_end;
  logic                   err_q;
  assign span_end    = {1'b0, sel_base} + (ADDRESS_WIDTH+1)'(sel_len);
  assign bad         = span_end[ADDRESS_WIDTH] || (32'(span_end) >= 32'(MEM_SIZE));
  assign accessError = err_q;
`else
  assign bad = 1'b0;
`endif

  assign last_beat = (beat == len);
  assign beat_addr = base + ADDRESS_WIDTH'(beat);

  always_comb begin
    state_nxt    = state;
    reqReady     = '0;
    wdataTake    = '0;
    busy         = 1'b0;
    writeEnable  = 1'b0;
    readAddress  = '0;
    writeAddress = '0;
    inputData    = '0;
    case (state)
      IDLE: begin
        // rst_n gate keeps the combinational grant quiet while reset is held.
        if (gnt_found && rst_n) begin
          reqReady[gnt_sel] = 1'b1;
          busy              = 1'b1;
          if (bad)
            state_nxt = DRAIN;
          else if (reqWrite[gnt_sel])
            state_nxt = WRITE;
          else
            state_nxt = READ;
        end
      end
      WRITE: begin
        busy           = 1'b1;
        writeEnable    = 1'b1;
        writeAddress   = beat_addr;
        inputData      = reqWriteData[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        wdataTake[gnt] = 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      READ: begin
        busy        = 1'b1;
        readAddress = beat_addr;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      base       <= '0;
      len        <= '0;
      beat       <= '0;
      rvalid_q   <= '0;
      rlast_q    <= 1'b0;
      rdata_hold <= '0;
`ifdef ARB_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      rvalid_q <= '0;
      rlast_q  <= 1'b0;
      if (state == IDLE && gnt_found) begin
        gnt  <= gnt_sel;
        base <= sel_base;
        len  <= sel_len;
        beat <= '0;
      end
      if (state == WRITE || state == READ)
        beat <= beat + LEN_WIDTH'(1);
      // Memory read data lands one cycle after the address, so the
      // valid/last qualifiers are simply the READ beat delayed by one.
      if (state == READ) begin
        rvalid_q[gnt] <= 1'b1;
        rlast_q       <= last_beat;
      end
      if (|rvalid_q)
        rdata_hold <= outputData;
      // Finished requester drops to lowest priority.
      if ((state == WRITE && last_beat) || state == DRAIN)
        ptr <= (gnt == PW'(NUM_REQ-1)) ? '0 : gnt + PW'(1);
`ifdef ARB_BOUNDS_CHECK_EN
      err_q <= (state == IDLE) && gnt_found && bad;
`endif
    end
  end

  assign rdataValid = rvalid_q;
  assign rdataLast  = rlast_q;
  assign rdata      = (|rvalid_q) ? outputData : rdata_hold;

endmodule

// File: tb/tb_vector_memory_arbiter.sv
module tb_vector_memory_arbiter;
  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 19;
  localparam int LW = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      reqValid, reqWrite, reqReady, wdataTake, rdataValid;
  logic [N*AW-1:0]   reqAddress;
  logic [N*LW-1:0]   reqLength;
  logic [N*DW-1:0]   reqWriteData;
  logic              rdataLast, busy, writeEnable;
  logic [DW-1:0]     rdata, inputData, outputData;
  logic [AW-1:0]     readAddress, writeAddress;
`ifdef ARB_BOUNDS_CHECK_EN
  logic              accessError;
`endif

  vector_memory_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                          .LEN_WIDTH(LW), .MEM_SIZE(1000)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqLength(reqLength), .reqWriteData(reqWriteData),
    .reqReady(reqReady), .wdataTake(wdataTake), .rdataValid(rdataValid),
    .rdataLast(rdataLast), .rdata(rdata), .busy(busy),
`ifdef ARB_BOUNDS_CHECK_EN
    .accessError(accessError),
`endif
    .writeEnable(writeEnable), .readAddress(readAddress),
    .writeAddress(writeAddress), .inputData(inputData), .outputData(outputData));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: registered read port, write on the rising edge.
  logic [DW-1:0] mem [int];
  always @(posedge clk) begin
    outputData <= mem.exists(int'(readAddress)) ? mem[int'(readAddress)] : '0;
    if (writeEnable) mem[int'(writeAddress)] = inputData;
  end

  // Monitor logs for the directed literal checks.
  logic [N-1:0]  grant_q[$];
  logic [AW-1:0] wa_q[$];
  int rv0_cnt = 0, rv1_cnt = 0, take1_cnt = 0;
  always @(negedge clk) begin
    if (reqReady != '0) grant_q.push_back(reqReady);
    if (writeEnable) wa_q.push_back(writeAddress);
    if (rdataValid[0]) rv0_cnt++;
    if (rdataValid[1]) rv1_cnt++;
    if (wdataTake[1]) take1_cnt++;
  end

  // Transaction-level model: a burst is a grant at t=0, then by cycle
  // offset t: writes at t=1..N, read addresses at t=1..N, read data at t=2..N+1.
  logic [DW-1:0] exp_mem [int];
  bit            m_active = 0;
  int            m_ptr = 0, m_g = 0, m_base = 0, m_n = 0, m_t = 0;
  bit            m_wr = 0;
  logic [DW-1:0] m_rd = '0;

  always @(negedge clk) begin
    logic [N-1:0]  e_ready, e_take, e_rv;
    logic          e_busy, e_we, e_last;
    logic [AW-1:0] e_wa, e_ra, a;
    logic [DW-1:0] e_wd;
    int            g;
    e_ready = '0; e_take = '0; e_rv = '0; e_busy = 0; e_we = 0; e_last = 0;
    e_wa = '0; e_ra = '0; e_wd = '0; a = '0; g = -1;
    if (!rst_n) begin
      m_active = 0; m_ptr = 0; m_rd = '0;
    end else if (!m_active) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && reqValid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        e_ready[g] = 1'b1; e_busy = 1;
        m_g = g; m_wr = reqWrite[g];
        m_base = int'(reqAddress[g*AW +: AW]);
        m_n = int'(reqLength[g*LW +: LW]) + 1;
        m_t = 0; m_active = 1;
      end
    end else begin
      m_t++;
      e_busy = 1;
      if (m_wr) begin
        e_we = 1; e_take[m_g] = 1'b1;
        e_wa = AW'(m_base + m_t - 1);
        e_wd = reqWriteData[m_g*DW +: DW];
        exp_mem[int'(e_wa)] = e_wd;
        if (m_t == m_n) begin m_active = 0; m_ptr = (m_g + 1) % N; end
      end else begin
        if (m_t <= m_n) e_ra = AW'(m_base + m_t - 1);
        if (m_t >= 2) begin
          a = AW'(m_base + m_t - 2);
          e_rv[m_g] = 1'b1;
          m_rd = exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : '0;
          if (m_t == m_n + 1) begin
            e_last = 1; m_active = 0; m_ptr = (m_g + 1) % N;
          end
        end
      end
    end
    chk("reqReady", reqReady, e_ready);
    chk("busy", busy, e_busy);
    chk("writeEnable", writeEnable, e_we);
    chk("writeAddress", writeAddress, e_wa);
    chk("inputData", inputData, e_wd);
    chk("wdataTake", wdataTake, e_take);
    chk("readAddress", readAddress, e_ra);
    chk("rdataValid", rdataValid, e_rv);
    chk("rdataLast", rdataLast, e_last);
    chk("rdata", rdata, m_rd);
  end

  task automatic set_req(input int i, input bit wr, input int base, input int len,
                         input logic [DW-1:0] d);
    reqWrite[i] = wr;
    reqAddress[i*AW +: AW] = AW'(base);
    reqLength[i*LW +: LW] = LW'(len);
    reqWriteData[i*DW +: DW] = d;
    reqValid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit ok;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (reqReady[i]) ok = 1;
    end
    chk("grant_seen", ok, 1'b1);
  endtask

  task automatic do_write(input int i, input int base, input int len,
                          input logic [DW-1:0] d0, input int drop);
    set_req(i, 1'b1, base, len, d0);
    wait_grant(i);
    @(posedge clk); #1;
    if (drop == 0) reqValid[i] = 1'b0;
    for (int b = 1; b <= len; b++) begin
      @(posedge clk); #1;
      reqWriteData[i*DW +: DW] = reqWriteData[i*DW +: DW] + 1;
      if (b == drop) reqValid[i] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  int wa_base, t_base, gq_base, rv0_base, rv1_base;
  logic [AW-1:0] wa_tmp;

  initial begin
    rst_n = 1'b0;
    reqValid = '0; reqWrite = '0; reqAddress = '0; reqLength = '0; reqWriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single-beat write of 0 to address 2.
    wa_base = wa_q.size();
    do_write(0, 2, 0, 64'h0, 0);
    chk("w1_count", wa_q.size() - wa_base, 1);
    if (wa_q.size() > wa_base) begin
      wa_tmp = wa_q[wa_base];
      chk("w1_addr", wa_tmp, 19'd2);
    end

    // Requester 1 drops reqValid during beat 1 of a 3-beat write.
    t_base = take1_cnt;
    do_write(1, 10, 2, 64'hA5A5_0000_0000_0010, 1);
    chk("drop_takes", take1_cnt - t_base, 3);

    // Write burst wrapping the top of the address space.
    wa_base = wa_q.size();
    do_write(0, 524286, 3, 64'h1111_0000_0000_0000, 0);
    chk("wrap_count", wa_q.size() - wa_base, 4);
    if (wa_q.size() >= wa_base + 4) begin
      wa_tmp = wa_q[wa_base];     chk("wrap_a0", wa_tmp, 19'd524286);
      wa_tmp = wa_q[wa_base + 1]; chk("wrap_a1", wa_tmp, 19'd524287);
      wa_tmp = wa_q[wa_base + 2]; chk("wrap_a2", wa_tmp, 19'd0);
      wa_tmp = wa_q[wa_base + 3]; chk("wrap_a3", wa_tmp, 19'd1);
    end

    // Single-beat read of address 2: data two cycles after the grant.
    set_req(0, 1'b0, 2, 0, '0);
    wait_grant(0);
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    @(negedge clk);
    chk("r1_early_valid", rdataValid, 2'b00);
    @(negedge clk);
    chk("r1_valid", rdataValid, 2'b01);
    chk("r1_last", rdataLast, 1'b1);
    chk("r1_data", rdata, 64'h0);
    @(posedge clk); #1;

    // Reset during READ beat 2 of a 4-beat burst.
    set_req(0, 1'b0, 10, 3, '0);
    wait_grant(0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    reqValid = '0;
    #1;
    chk("rst_rvalid", rdataValid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_raddr", readAddress, 19'd0);
    rv0_base = rv0_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_rvalid", rv0_cnt - rv0_base, 0);

    // Both requesters reading from reset release: order 0, 1, 0.
    set_req(0, 1'b0, 10, 3, '0);
    set_req(1, 1'b0, 524286, 3, '0);
    gq_base = grant_q.size();
    rv0_base = rv0_cnt;
    rv1_base = rv1_cnt;
    rst_n = 1'b1;
    for (int c = 0; c < 60 && grant_q.size() < gq_base + 3; c++) @(negedge clk);
    chk("rr_grants", grant_q.size() - gq_base, 3);
    @(posedge clk); #1;
    reqValid = '0;
    repeat (8) @(posedge clk);
    #1;
    if (grant_q.size() >= gq_base + 3) begin
      chk("rr_first", grant_q[gq_base], 2'b01);
      chk("rr_second", grant_q[gq_base + 1], 2'b10);
      chk("rr_third", grant_q[gq_base + 2], 2'b01);
    end
    chk("rr_rv0_beats", rv0_cnt - rv0_base, 8);
    chk("rr_rv1_beats", rv1_cnt - rv1_base, 4);
    chk("end_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
